// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: five-way round-robin arbiter sequencing single-port async SRAM accesses
module sram_rr_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [4:0]  req_valid,
  input  logic [4:0]  req_we,
  input  logic [79:0] req_addr,
  input  logic [79:0] req_wdata,
  output logic [4:0]  done,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        sram_wdata_oe,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  input  logic [15:0] sram_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, TURN} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [2:0] rr_ptr, idx, gnt, c;
  logic gnt_ok, we, a_we;
  logic [15:0] addr, wdata, a_addr, a_wdata;
  // scan farthest to nearest so the closest requester after rr_ptr wins
  always_comb begin
    gnt = rr_ptr;
    gnt_ok = 1'b0;
    c = '0;
    for (int k = 5; k >= 1; k--) begin
      c = 3'((32'(rr_ptr) + k) % 5);
      if (req_valid[c]) begin
        gnt = c;
        gnt_ok = 1'b1;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (run && gnt_ok) ? ACCESS : IDLE;
      ACCESS:  nxt = (cnt == 4'(ACCESS_CYCLES - 1)) ? DONE : ACCESS;
      DONE:    nxt = (TURN_CYCLES > 0) ? TURN : IDLE;
      default: nxt = (cnt == 4'(TURN_CYCLES - 1)) ? IDLE : TURN;
    endcase
  end
  // bus values for the upcoming ACCESS cycle: fresh request on grant, latched copy afterwards
  assign a_we    = (state == IDLE) ? req_we[gnt] : we;
  assign a_addr  = (state == IDLE) ? req_addr[{gnt, 4'b0} +: 16] : addr;
  assign a_wdata = (state == IDLE) ? req_wdata[{gnt, 4'b0} +: 16] : wdata;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rr_ptr <= 3'd4;
      idx <= '0;
      we <= 1'b0;
      addr <= '0;
      wdata <= '0;
      done <= '0;
      rdata <= '0;
      busy <= 1'b0;
      sram_addr <= 16'hFFFF;
      sram_wdata <= '0;
      sram_wdata_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
    end else begin
      state <= nxt;
      cnt <= (nxt != state) ? 4'd0 : cnt + 4'd1;
      busy <= (nxt != IDLE);
      done <= (nxt == DONE) ? 5'(1) << idx : 5'd0;
      if (state == IDLE && nxt == ACCESS) begin
        rr_ptr <= gnt;
        idx <= gnt;
        we <= a_we;
        addr <= a_addr;
        wdata <= a_wdata;
      end
      if (state == ACCESS && nxt == DONE && !we) rdata <= sram_rdata;
      sram_ce_n <= (nxt != ACCESS);
      sram_addr <= (nxt == ACCESS) ? a_addr : 16'hFFFF;
      sram_wdata <= (nxt == ACCESS) ? a_wdata : 16'h0000;
      sram_wdata_oe <= (nxt == ACCESS) && a_we;
      sram_we_n <= !((nxt == ACCESS) && a_we);
      sram_oe_n <= !((nxt == ACCESS) && !a_we);
    end
  end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: directed and random checks against a transaction-timeline model
module tb_sram_rr_arbiter;
  localparam int A = 2;
  localparam int T = 1;
  logic clk = 0, reset = 1, run = 0;
  logic [4:0] req_valid = 0, req_we = 0;
  logic [79:0] req_addr = 0, req_wdata = 0;
  logic [15:0] sram_rdata = 0;
  logic [4:0] done;
  logic [15:0] rdata, sram_addr, sram_wdata;
  logic busy, sram_wdata_oe, sram_ce_n, sram_we_n, sram_oe_n;
  int tests = 0, fails = 0;
  int cyc = 0, free_at = 0, acc_start = -1, acc_end = -1, done_cyc = -1, mptr = 4;
  logic [2:0] g_idx = 0;
  logic g_we = 0, hold = 0, scr = 0;
  logic [15:0] g_addr = 0, g_wdata = 0, exp_rdata = 0;
  int dq[$];
  int rr_exp[6] = '{0, 1, 2, 3, 4, 0};
  int ct_exp[3] = '{3, 4, 3};

  always #5 clk = ~clk;

  sram_rr_arbiter #(.ACCESS_CYCLES(A), .TURN_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .run(run), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_rdata(sram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    free_at = 0; acc_start = -1; acc_end = -1; done_cyc = -1; mptr = 4; exp_rdata = 0;
  endtask

  task automatic check_outputs();
    logic acc;
    logic [4:0] ed;
    acc = (cyc >= acc_start && cyc <= acc_end);
    ed = (cyc == done_cyc) ? 5'(1) << g_idx : 5'd0;
    chk("busy", 32'(busy), 32'(cyc < free_at));
    chk("done", 32'(done), 32'(ed));
    chk("rdata", 32'(rdata), 32'(exp_rdata));
    chk("ce_n", 32'(sram_ce_n), 32'(!acc));
    chk("addr", 32'(sram_addr), acc ? 32'(g_addr) : 32'hFFFF);
    chk("we_n", 32'(sram_we_n), 32'(!(acc && g_we)));
    chk("oe_n", 32'(sram_oe_n), 32'(!(acc && !g_we)));
    chk("wdata_oe", 32'(sram_wdata_oe), 32'(acc && g_we));
    chk("wdata", 32'(sram_wdata), acc ? 32'(g_wdata) : 32'h0);
    if (done != 0) dq.push_back($clog2(done));
  endtask

  // a grant in cycle g occupies access g+1..g+A, done g+A+1, turn, idle again at g+A+2+T
  task automatic model_update();
    int win;
    if (reset) return;
    if (cyc == acc_end && !g_we) exp_rdata = sram_rdata;
    if (cyc >= free_at && run && req_valid != 0) begin
      win = -1;
      for (int k = 1; k <= 5; k++) if (win < 0 && req_valid[(mptr + k) % 5]) win = (mptr + k) % 5;
      mptr = win;
      g_idx = 3'(win);
      g_we = req_we[win];
      g_addr = req_addr[16*win +: 16];
      g_wdata = req_wdata[16*win +: 16];
      acc_start = cyc + 1;
      acc_end = cyc + A;
      done_cyc = cyc + A + 1;
      free_at = cyc + A + 2 + T;
    end
  endtask

  task automatic step();
    logic [4:0] drop;
    @(negedge clk);
    check_outputs();
    drop = (!reset && cyc == done_cyc) ? 5'(1) << g_idx : 5'd0;
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    if (!hold) req_valid &= ~drop;
    if (scr) begin
      for (int i = 0; i < 5; i++) begin
        req_addr[16*i +: 16] = 16'($urandom);
        req_wdata[16*i +: 16] = 16'($urandom);
      end
      req_we = 5'($urandom);
      sram_rdata = 16'($urandom);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) step();
    reset = 0;
    run = 1;
    req_addr[47:32] = 16'h0123;
    sram_rdata = 16'hBEEF;
    req_valid = 5'b00100;
    repeat (8) step();
    chk("read_rdata", 32'(rdata), 32'hBEEF);
    chk("read_order", 32'(dq.size() == 1 && dq[0] == 2), 32'd1);
    dq.delete();
    req_we = 5'b00010;
    req_addr[31:16] = 16'h0040;
    req_wdata[31:16] = 16'hA5A5;
    req_valid = 5'b00010;
    step();
    req_addr[31:16] = 16'hDEAD;
    req_wdata[31:16] = 16'h1111;
    repeat (7) step();
    chk("write_rdata", 32'(rdata), 32'hBEEF);
    chk("write_order", 32'(dq.size() == 1 && dq[0] == 1), 32'd1);
    req_we = 0;
    reset = 1;
    model_reset();
    step();
    reset = 0;
    dq.delete();
    hold = 1;
    req_valid = 5'b11111;
    repeat (32) step();
    hold = 0;
    chk("rr_count", 32'(dq.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) chk("rr_order", (dq.size() > i) ? 32'(dq[i]) : 32'hFFFF, 32'(rr_exp[i]));
    repeat (40) step();
    dq.delete();
    req_valid = 5'b01000;
    repeat (8) step();
    req_valid = req_valid | 5'b11000;
    repeat (14) step();
    for (int i = 0; i < 3; i++) chk("contention_order", (dq.size() > i) ? 32'(dq[i]) : 32'hFFFF, 32'(ct_exp[i]));
    dq.delete();
    req_valid = 5'b00001;
    step();
    run = 0;
    repeat (6) step();
    chk("gate_done", 32'(dq.size()), 32'd1);
    req_valid = 5'b11111;
    repeat (10) step();
    chk("gate_nogrant", 32'(dq.size()), 32'd1);
    chk("gate_busy", 32'(busy), 32'd0);
    run = 1;
    repeat (30) step();
    dq.delete();
    req_valid = 5'b00100;
    step();
    reset = 1;
    #1;
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    model_reset();
    repeat (2) step();
    reset = 0;
    req_valid = 5'b11111;
    repeat (8) step();
    chk("rst_first", (dq.size() > 0) ? 32'(dq[0]) : 32'hFFFF, 32'd0);
    repeat (30) step();
    scr = 1;
    for (int n = 0; n < 600; n++) begin
      run = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < 5; i++) if (!req_valid[i] && $urandom_range(0, 3) == 0) req_valid[i] = 1'b1;
      step();
    end
    run = 1;
    repeat (60) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
